// File: rtl/beeper_pkg.sv
// Beeper constants: 5-bit tone codes, 12 MHz PWM period table, note ROM entry layout.
// Pure definitions; no timing or flow control.
package beeper_pkg;

    localparam logic [4:0] REST = 5'd0;
    localparam logic [4:0] L1 = 5'd1,  L2 = 5'd2,  L3 = 5'd3,  L4 = 5'd4,  L5 = 5'd5,  L6 = 5'd6,  L7 = 5'd7;
    localparam logic [4:0] M1 = 5'd8,  M2 = 5'd9,  M3 = 5'd10, M4 = 5'd11, M5 = 5'd12, M6 = 5'd13, M7 = 5'd14;
    localparam logic [4:0] H1 = 5'd15, H2 = 5'd16, H3 = 5'd17, H4 = 5'd18, H5 = 5'd19, H6 = 5'd20, H7 = 5'd21;

    localparam int ENTRY_W   = 9;
    localparam int TONE_MSB  = 8;
    localparam int TONE_LSB  = 4;
    localparam int BEATS_MSB = 3;
    localparam int BEATS_LSB = 0;
    localparam logic [3:0] END_BEATS = 4'd0;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    // Just-intonation scale anchored on mid do = 22944 clocks; codes 22..31 play as rest.
    localparam logic [15:0] TONE_CYCLE [32] = '{
        16'd0,
        16'd45888, 16'd40789, 16'd36710, 16'd34416, 16'd30592, 16'd27533, 16'd24474,
        16'd22944, 16'd20395, 16'd18355, 16'd17208, 16'd15296, 16'd13766, 16'd12237,
        16'd11472, 16'd10197, 16'd9178,  16'd8604,  16'd7648,  16'd6883,  16'd6118,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };

endpackage

// File: rtl/melody_rom.sv
// Note ROM, 2**ADDR_W x 9, contents given by INIT (image of the song init file).
// One-clock synchronous read; always ready, no backpressure.
module melody_rom
    import beeper_pkg::*;
#(
    parameter int                               ADDR_W = 6,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0]   INIT   = '0
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_dat
);

    logic [ENTRY_W-1:0] w_mem [2**ADDR_W];
    logic [ENTRY_W-1:0] r_dat;

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_img
        assign w_mem[g] = INIT[g*ENTRY_W +: ENTRY_W];
    end

    always_ff @(posedge clk) begin
        r_dat <= w_mem[i_addr];
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer driving the PWM period word from the note ROM; MELODY_LOOP_EN repeats the song.
// First tone 2 clocks after start is sampled, all outputs registered; stop aborts on the next clock.
module melody_player
    import beeper_pkg::*;
#(
    parameter int                             BEAT_CYCLES = 3_000_000,
    parameter int                             GAP_CYCLES  = 120_000,
    parameter int                             ADDR_W      = 6,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0] ROM_INIT    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [15:0]       cycle,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_addr
);

    localparam int TMR_W = $clog2(15 * BEAT_CYCLES);
    localparam logic [TMR_W-1:0] BEAT_X1  = TMR_W'(BEAT_CYCLES);
    localparam logic [TMR_W-1:0] BEAT_X2  = BEAT_X1 << 1;
    localparam logic [TMR_W-1:0] BEAT_X4  = BEAT_X1 << 2;
    localparam logic [TMR_W-1:0] BEAT_X8  = BEAT_X1 << 3;
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    state_t              r_state, w_state_nxt;
    logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [15:0]         r_cycle, w_cycle_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_eos;
    logic [ENTRY_W-1:0]  w_rom_dat;
    logic [4:0]          w_tone;
    logic [3:0]          w_beats;
    logic [TMR_W-1:0]    w_play_len;
    logic                w_last_addr;

    melody_rom #(
        .ADDR_W (ADDR_W),
        .INIT   (ROM_INIT)
    ) u_rom (
        .clk    (clk),
        .i_addr (r_addr),
        .o_dat  (w_rom_dat)
    );

    assign w_tone      = w_rom_dat[TONE_MSB:TONE_LSB];
    assign w_beats     = w_rom_dat[BEATS_MSB:BEATS_LSB];
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});

    // beats * BEAT_CYCLES - 1 built from pre-shifted constants, so no runtime multiplier.
    assign w_play_len = (w_beats[0] ? BEAT_X1 : '0) + (w_beats[1] ? BEAT_X2 : '0)
                      + (w_beats[2] ? BEAT_X4 : '0) + (w_beats[3] ? BEAT_X8 : '0)
                      - TMR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_addr_nxt  = r_addr;
        w_cycle_nxt = r_cycle;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_eos       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cycle_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (start) begin
                    w_addr_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: w_state_nxt = LOAD;
            LOAD: begin
                if (w_beats == END_BEATS) begin
                    w_eos = 1'b1;
                end else begin
                    w_tmr_nxt   = w_play_len;
                    w_cycle_nxt = TONE_CYCLE[w_tone];
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (r_tmr == '0) begin
                    w_cycle_nxt = '0;
                    w_tmr_nxt   = GAP_LOAD;
                    w_state_nxt = GAP;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            GAP: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end else if (w_last_addr) begin
                    w_eos = 1'b1;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_eos) begin
            w_done_nxt  = 1'b1;
            w_cycle_nxt = '0;
`ifdef MELODY_LOOP_EN
            w_addr_nxt  = '0;
            w_state_nxt = FETCH;
`else
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
`endif
        end

        if (stop) begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = '0;
            w_cycle_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_addr  <= '0;
            r_cycle <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_addr  <= w_addr_nxt;
            r_cycle <= w_cycle_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign cycle     = r_cycle;
    assign busy      = r_busy;
    assign done      = r_done;
    assign note_addr = r_addr;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: expected per-clock output traces are queued at stimulus time.
module tb_melody_player;

    localparam int BEAT = 10;
    localparam int GAPC = 2;
    localparam int AW   = 3;

    // Entry = {tone[4:0], beats[3:0]}; entry 0 in the low bits.
    // Song: {M1,2},{REST,1},{M5,1},{END}
    localparam logic [71:0] SONG_IMG = {9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h0C1, 9'h001, 9'h082};
    // Full: M1,M5,H1,L1,code25,M1,M5,H1 all 1 beat, no marker
    localparam logic [71:0] FULL_IMG = {9'h0F1, 9'h0C1, 9'h081, 9'h191, 9'h011, 9'h0F1, 9'h0C1, 9'h081};

    typedef struct packed {
        logic [15:0] cyc;
        logic        busy;
        logic        done;
        logic [2:0]  addr;
        logic        chk_addr;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start_a, stop_a, start_b, stop_b;
    logic [15:0]   cyc_a, cyc_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [AW-1:0] addr_a, addr_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t trace[$];
    int   done_idx;
    int   n_checks = 0;
    int   n_fail   = 0;

    melody_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .ADDR_W(AW), .ROM_INIT(SONG_IMG)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .cycle(cyc_a), .busy(busy_a), .done(done_a), .note_addr(addr_a)
    );

    melody_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .ADDR_W(AW), .ROM_INIT(FULL_IMG)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .cycle(cyc_b), .busy(busy_b), .done(done_b), .note_addr(addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] tone_per(input logic [4:0] code);
        case (code)
            5'd1:    return 16'd45888;
            5'd8:    return 16'd22944;
            5'd12:   return 16'd15296;
            5'd15:   return 16'd11472;
            default: return 16'd0;
        endcase
    endfunction

    function automatic exp_t mk(input logic [15:0] c, input logic b, input logic d, input int a, input logic ck);
        exp_t e;
        e.cyc = c; e.busy = b; e.done = d; e.addr = 3'(a); e.chk_addr = ck;
        return e;
    endfunction

    function automatic logic [8:0] rom_img(input int sel, input int a);
        logic [71:0] img;
        img = (sel == 0) ? SONG_IMG : FULL_IMG;
        return img[a*9 +: 9];
    endfunction

    task automatic check(input string tag, input exp_t e, input logic [15:0] c,
                         input logic b, input logic d, input logic [2:0] a);
        n_checks++;
        if (c !== e.cyc || b !== e.busy || d !== e.done || (e.chk_addr && a !== e.addr)) begin
            n_fail++;
            $display("FAIL %s @%0t: got cycle=%0d busy=%b done=%b addr=%0d, want cycle=%0d busy=%b done=%b addr=%0d",
                     tag, $time, c, b, d, a, e.cyc, e.busy, e.done, e.addr);
        end
    endtask

    // Monitor: one expected entry consumed per clock while a trace is pending.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("song", e, cyc_a, busy_a, done_a, addr_a);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("full", e, cyc_b, busy_b, done_b, addr_b);
        end
    end

    // Entry j = outputs after edge e0+j, where start is sampled at edge e0+1.
    task automatic build_trace(input int sel);
        int         a;
        int         passes;
        bit         fin;
        logic [8:0] e;
        int         nb;
        trace.delete();
        done_idx = -1;
`ifdef MELODY_LOOP_EN
        passes = 2;
`else
        passes = 1;
`endif
        trace.push_back(mk(16'd0, 1'b0, 1'b0, 0, 1'b0));
        for (int p = 0; p < passes; p++) begin
            a = 0;
            fin = 1'b0;
            while (!fin) begin
                e = rom_img(sel, a);
                if (!(p > 0 && a == 0)) trace.push_back(mk(16'd0, 1'b1, 1'b0, a, 1'b1));
                trace.push_back(mk(16'd0, 1'b1, 1'b0, a, 1'b1));
                if (e[3:0] == 4'd0) begin
                    fin = 1'b1;
                end else begin
                    nb = int'(e[3:0]) * BEAT;
                    for (int i = 0; i < nb; i++) trace.push_back(mk(tone_per(e[8:4]), 1'b1, 1'b0, a, 1'b1));
                    for (int i = 0; i < GAPC; i++) trace.push_back(mk(16'd0, 1'b1, 1'b0, a, 1'b1));
                    if (a == 7) fin = 1'b1;
                    else a++;
                end
            end
            if (done_idx < 0) done_idx = trace.size();
`ifdef MELODY_LOOP_EN
            trace.push_back(mk(16'd0, 1'b1, 1'b1, 0, 1'b1));
`else
            trace.push_back(mk(16'd0, 1'b0, 1'b1, 0, 1'b0));
            repeat (2) trace.push_back(mk(16'd0, 1'b0, 1'b0, 0, 1'b0));
`endif
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic drive_stop(input int sel, input logic v);
        if (sel == 0) stop_a = v; else stop_b = v;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
        #1;
        if (qa.size() > 0 || qb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s drain: %0d entries left, want 0", tag, qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    // abort_kind: 0 none, 1 stop, 2 async reset; start_at < 0 means the done clock.
    task automatic run(input string tag, input int sel, input int abort_at, input int abort_kind, input int start_at);
        int s_at, a_at, kind, n;
        build_trace(sel);
        s_at = (start_at < 0) ? done_idx : start_at;
        a_at = abort_at;
        kind = abort_kind;
`ifdef MELODY_LOOP_EN
        if (a_at == 0) begin
            a_at = trace.size();
            kind = 1;
        end
`endif
        if (a_at > 0) begin
            while (trace.size() > a_at) void'(trace.pop_back());
            repeat (3) trace.push_back(mk(16'd0, 1'b0, 1'b0, 0, kind == 2));
        end
        n = trace.size();
        @(posedge clk); #1;
        foreach (trace[i]) begin
            if (sel == 0) qa.push_back(trace[i]);
            else qb.push_back(trace[i]);
        end
        drive_start(sel, 1'b1);
        for (int j = 1; j < n; j++) begin
            @(posedge clk); #1;
            drive_start(sel, j == s_at - 1);
            drive_stop(sel, kind == 1 && j == a_at - 1);
            if (kind == 2 && j == a_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " async"}, mk(16'd0, 1'b0, 1'b0, 0, 1'b1), cyc_a, busy_a, done_a, addr_a);
            end
            if (kind == 2 && j == a_at + 2) rst_n = 1'b1;
        end
        drain(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; stop_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0;
        #2;
        check("reset_a", mk(16'd0, 1'b0, 1'b0, 0, 1'b1), cyc_a, busy_a, done_a, addr_a);
        check("reset_b", mk(16'd0, 1'b0, 1'b0, 0, 1'b1), cyc_b, busy_b, done_b, addr_b);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Whole song, plus a start landing on the clock playback returns to idle.
        run("song", 0, 0, 0, -1);
        // Stop 5 clocks into the M5 note (M5 occupies entries 41..50).
        run("stop_m5", 0, 46, 1, 0);
        // Replay from addr 0 with a start pulse mid-PLAY that must be ignored.
        run("start_in_play", 0, 0, 0, 10);

        // start and stop together while idle: stays idle.
        @(posedge clk); #1;
        repeat (4) qa.push_back(mk(16'd0, 1'b0, 1'b0, 0, 1'b0));
        start_a = 1'b1; stop_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; stop_a = 1'b0;
        drain("start_stop_idle");

        // Fully populated ROM: done after the gap of note 7.
        run("full_rom", 1, 0, 0, 0);
        // Asynchronous reset in the middle of the first note.
        run("reset_play", 0, 15, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
